muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes one rs_entry_t per operation from its reservation station over the issue valid/ready handshake, where the RS is the initiator.
- Reads both source operands from a physical register file (PRF) read port.
- Computes over multiple cycles, then drives its own writeback bus (wb_mdu_o). The RS instances use that bus as a wakeup source and the ROB uses it as the completion source.

---
 rtl/ooop_types.sv | 67 ++++++
 rtl/muldiv_core.sv | 85 ++++++++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooop_types.sv
// rtl/ooop_types.sv - shared types for the out-of-order core: RS entry, writeback packet, MDU enums
//
// Purpose: common widths, the reservation-station entry and writeback packet
// formats, and the multiply/divide unit op/state encodings.
package ooop_types;

  localparam int OOOP_XLEN = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;
  localparam int MDU_ITERS = OOOP_XLEN;

  // Encoded exactly as the RV32M funct3 field.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_LOAD = 2'd1,
    MDU_EXEC = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic                 rd_used;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [2:0]           funct3;
  } rs_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 rd_used;
    logic [PREG_W-1:0]    prd;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [OOOP_XLEN-1:0] data;
  } wb_pkt_t;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  // MUL is treated as signed x signed: its low word is the same either way.
  function automatic logic op_a_signed(input mdu_op_e op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - radix-2 iterative unsigned multiply / restoring divide datapath
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       load operands and begin ITERS steps
//   is_div_i      1 = divide a_i / b_i, 0 = multiply a_i * b_i (both unsigned magnitudes)
//   a_i, b_i      operand magnitudes
//   done_o        high during the last step; hi_o/lo_o then hold the final result
//   hi_o, lo_o    mul: product high/low word; div: remainder/quotient
module muldiv_core
  import ooop_types::*;
#(
  parameter int XLEN  = OOOP_XLEN,
  parameter int ITERS = MDU_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CNT_W = $clog2(ITERS) + 1;

  logic             running_q;
  logic             is_div_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  // Mul: {hi,lo} holds partial product over the remaining multiplier bits in lo.
  // Div: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div_q) begin
      step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Results are presented one step early so the caller can register them on the
  // same edge the final step lands.
  assign done_o = running_q && (cnt_q == CNT_W'(ITERS - 1));
  assign hi_o   = step_hi;
  assign lo_o   = step_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      is_div_q  <= is_div_i;
      hi_q      <= '0;
      lo_q      <= a_i;
      b_q       <= b_i;
      cnt_q     <= '0;
    end else if (running_q) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) begin
        running_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i, recover_i       full flush / branch recovery (live_tag_i valid with recover_i)
//   issue_valid_i/_entry_i   RS offers an entry; issue_ready_o grants it
//   prf_raddr1/2_o           PRF read addresses; prf_rdata1/2_i arrive one cycle later
//   wb_mdu_o                 registered writeback, one-cycle valid
//   busy_o                   unit is not idle
// Build option: MDU_FAST_MUL_EN selects a single-cycle 33x33 multiplier for MUL*.
module muldiv_unit
  import ooop_types::*;
#(
  parameter int XLEN  = OOOP_XLEN,
  parameter int ITERS = MDU_ITERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 recover_i,
  input  logic [ROB_DEPTH-1:0] live_tag_i,
  input  logic                 issue_valid_i,
  input  rs_entry_t            issue_entry_i,
  output logic                 issue_ready_o,
  output logic [PREG_W-1:0]    prf_raddr1_o,
  output logic [PREG_W-1:0]    prf_raddr2_o,
  input  logic [XLEN-1:0]      prf_rdata1_i,
  input  logic [XLEN-1:0]      prf_rdata2_i,
  output wb_pkt_t              wb_mdu_o,
  output logic                 busy_o
);

  mdu_state_e state_q, state_d;
  rs_entry_t  entry_q, entry_d;
  logic       neg_res_q, neg_res_d;  // negate product / quotient
  logic       neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  wb_pkt_t    wb_q, wb_d;

  logic            fire, squash;
  mdu_op_e         op;
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;
  logic            core_start, core_done;
  logic [XLEN-1:0] core_hi, core_lo;
  logic [2*XLEN-1:0] prod_abs, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, exec_res;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  assign issue_ready_o = (state_q == MDU_IDLE) && !flush_i && !recover_i && !rst;
  assign fire          = issue_valid_i && issue_ready_o;
  assign busy_o        = (state_q != MDU_IDLE);
  assign wb_mdu_o      = wb_q;

  // In IDLE the PRF is addressed straight from the offered entry so the data
  // is ready in LOAD, the cycle after the grant.
  assign prf_raddr1_o = (state_q == MDU_IDLE) ? issue_entry_i.prs1 : entry_q.prs1;
  assign prf_raddr2_o = (state_q == MDU_IDLE) ? issue_entry_i.prs2 : entry_q.prs2;

  // Operand decode, only meaningful in LOAD.
  assign op       = mdu_op_e'(entry_q.funct3);
  assign a_sgn    = op_a_signed(op) && prf_rdata1_i[XLEN-1];
  assign b_sgn    = op_b_signed(op) && prf_rdata2_i[XLEN-1];
  assign a_mag    = a_sgn ? -prf_rdata1_i : prf_rdata1_i;
  assign b_mag    = b_sgn ? -prf_rdata2_i : prf_rdata2_i;
  assign div_zero = op_is_div(op) && (prf_rdata2_i == '0);
  assign div_ovf  = op_is_div(op) && op_a_signed(op) &&
                    (prf_rdata1_i == INT_MIN) && (prf_rdata2_i == '1);
  assign spec_res = div_zero ? (op_is_rem(op) ? prf_rdata1_i : '1)
                             : (op_is_rem(op) ? '0 : INT_MIN);

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_prod;
  logic [XLEN-1:0]          fm_res;
  logic [1:0]               unused_fm_top;

  assign fm_a          = {op_a_signed(op) & prf_rdata1_i[XLEN-1], prf_rdata1_i};
  assign fm_b          = {op_b_signed(op) & prf_rdata2_i[XLEN-1], prf_rdata2_i};
  assign fm_prod       = fm_a * fm_b;
  assign fm_res        = (op == MDU_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
  assign unused_fm_top = fm_prod[2*XLEN+1:2*XLEN];
`endif

  muldiv_core #(
    .XLEN  (XLEN),
    .ITERS (ITERS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (core_start),
    .is_div_i (op_is_div(op)),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .done_o   (core_done),
    .hi_o     (core_hi),
    .lo_o     (core_lo)
  );

  // Sign correction of the magnitude result from the core.
  assign prod_abs = {core_hi, core_lo};
  assign prod_fix = neg_res_q ? -prod_abs : prod_abs;
  assign quot_fix = neg_res_q ? -core_lo : core_lo;
  assign rem_fix  = neg_rem_q ? -core_hi : core_hi;
  assign exec_res = op_is_div(op) ? (op_is_rem(op) ? rem_fix : quot_fix)
                                  : ((op == MDU_MUL) ? prod_fix[XLEN-1:0]
                                                     : prod_fix[2*XLEN-1:XLEN]);

  assign squash = busy_o && recover_i && !live_tag_i[entry_q.rob_tag];

  function automatic wb_pkt_t make_wb(input rs_entry_t e, input logic [XLEN-1:0] d);
    wb_pkt_t w;
    w.valid   = 1'b1;
    w.rd_used = e.rd_used;
    w.prd     = e.prd;
    w.rob_tag = e.rob_tag;
    w.data    = d;
    return w;
  endfunction

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    wb_d       = '0;
    core_start = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (fire) begin
          entry_d = issue_entry_i;
          state_d = MDU_LOAD;
        end
      end
      MDU_LOAD: begin
        neg_res_d = a_sgn ^ b_sgn;
        neg_rem_d = a_sgn;
        if (div_zero || div_ovf) begin
          state_d = MDU_DONE;
          wb_d    = make_wb(entry_q, spec_res);
        end
`ifdef MDU_FAST_MUL_EN
        else if (!op_is_div(op)) begin
          state_d = MDU_DONE;
          wb_d    = make_wb(entry_q, fm_res);
        end
`endif
        else begin
          state_d    = MDU_EXEC;
          core_start = 1'b1;
        end
      end
      MDU_EXEC: begin
        if (core_done) begin
          state_d = MDU_DONE;
          wb_d    = make_wb(entry_q, exec_res);
        end
      end
      MDU_DONE: begin
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
    // A squash in DONE cannot retract the packet already on the bus; consumers
    // filter it by tag.
    if (flush_i || squash) begin
      state_d = MDU_IDLE;
      wb_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      entry_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      wb_q      <= wb_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
  import ooop_types::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush_i;
  logic                 recover_i;
  logic [ROB_DEPTH-1:0] live_tag_i;
  logic                 issue_valid_i;
  rs_entry_t            issue_entry_i;
  logic                 issue_ready_o;
  logic [PREG_W-1:0]    prf_raddr1_o, prf_raddr2_o;
  logic [31:0]          prf_rdata1_i, prf_rdata2_i;
  wb_pkt_t              wb_mdu_o;
  logic                 busy_o;

  muldiv_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .recover_i     (recover_i),
    .live_tag_i    (live_tag_i),
    .issue_valid_i (issue_valid_i),
    .issue_entry_i (issue_entry_i),
    .issue_ready_o (issue_ready_o),
    .prf_raddr1_o  (prf_raddr1_o),
    .prf_raddr2_o  (prf_raddr2_o),
    .prf_rdata1_i  (prf_rdata1_i),
    .prf_rdata2_i  (prf_rdata2_i),
    .wb_mdu_o      (wb_mdu_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous PRF read model.
  logic [31:0] regs [64];
  always @(posedge clk) begin
    prf_rdata1_i <= regs[prf_raddr1_o];
    prf_rdata2_i <= regs[prf_raddr2_o];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [5:0]  prd;
    logic [3:0]  tag;
    logic        rdu;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wb_mdu_o.valid) begin
        if (sb.size() == 0) begin
          check_eq("wb_unexpected", 64'(wb_mdu_o.rob_tag), 64'hdead);
        end else begin
          mon_e = sb.pop_front();
          check_eq("wb_cycle",   64'(cyc), 64'(mon_e.due));
          check_eq("wb_data",    64'(wb_mdu_o.data), 64'(mon_e.data));
          check_eq("wb_prd",     64'(wb_mdu_o.prd), 64'(mon_e.prd));
          check_eq("wb_rob_tag", 64'(wb_mdu_o.rob_tag), 64'(mon_e.tag));
          check_eq("wb_rd_used", 64'(wb_mdu_o.rd_used), 64'(mon_e.rdu));
        end
      end else begin
        check_eq("wb_idle_zero", 64'(wb_mdu_o), 64'h0);
        if (sb.size() > 0 && cyc > sb[0].due) begin
          check_eq("wb_missing", 64'(cyc), 64'(sb[0].due));
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p, q;
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ea  = (f3 <= 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb  = (f3 <= 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p   = ea * eb;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        q = sa / sb_;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb_;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hffffffff))) return 2;
`ifdef MDU_FAST_MUL_EN
    if (!f3[2]) return 2;
`endif
    return 34;
  endfunction

  // Call at a negedge (or just after one). Returns at posedge+1 of the fire cycle.
  task automatic do_issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] prd, input logic [3:0] tag, input logic rdu,
                          input logic [31:0] exp_data, input bit expect_wb, output int t_fire);
    int          waited;
    logic [5:0]  p1, p2;
    logic [31:0] r;
    rs_entry_t   e;
    exp_t        x;
    p1 = 6'($urandom_range(1, 31));
    p2 = p1 + 6'd32;
    regs[p1] = a;
    regs[p2] = b;
    e.prs1 = p1; e.prs2 = p2; e.prd = prd; e.rd_used = rdu; e.rob_tag = tag; e.funct3 = f3;
    issue_entry_i = e;
    issue_valid_i = 1'b1;
    #1;
    waited = 0;
    while (!issue_ready_o && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!issue_ready_o) begin
      check_eq("issue_grant_timeout", 64'(issue_ready_o), 64'h1);
      issue_valid_i = 1'b0;
      t_fire = -1;
      return;
    end
    check_eq("raddr1_idle", 64'(prf_raddr1_o), 64'(p1));
    t_fire = cyc;
    if (expect_wb) begin
      x.prd = prd; x.tag = tag; x.rdu = rdu; x.data = exp_data;
      x.due = t_fire + exp_lat(f3, a, b);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
    r = $urandom;
    issue_entry_i = rs_entry_t'(r[$bits(rs_entry_t)-1:0]);
    #1;
    check_eq("raddr1_latched", 64'(prf_raddr1_o), 64'(p1));
    check_eq("raddr2_latched", 64'(prf_raddr2_o), 64'(p2));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy_o) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_queue", 64'(sb.size()), 64'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    logic [2:0]  f3;
    logic [31:0] ra, rb;

    rst = 1'b1; flush_i = 1'b0; recover_i = 1'b0; live_tag_i = '1;
    issue_valid_i = 1'b1; issue_entry_i = '0;
    for (int i = 0; i < 64; i++) regs[i] = 32'(i * 3);
    prf_rdata1_i = '0; prf_rdata2_i = '0;

    // Reset state (valid held high: ready must still be 0)
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(issue_ready_o), 64'h0);
    check_eq("rst_busy",  64'(busy_o), 64'h0);
    check_eq("rst_wb",    64'(wb_mdu_o), 64'h0);
    issue_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 64'(issue_ready_o), 64'h1);
    mon_en = 1'b1;
    @(negedge clk);

    // DIVU 100 / 7
    do_issue(3'd5, 32'd100, 32'd7, 6'd12, 4'd3, 1'b1, 32'd14, 1'b1, t0);
    check_eq("ready_after_fire", 64'(issue_ready_o), 64'h0);
    check_eq("busy_after_fire",  64'(busy_o), 64'h1);
    drain();

    // Special divides and multiplies
    do_issue(3'd4, 32'h80000000, 32'hffffffff, 6'd5, 4'd1, 1'b1, 32'h80000000, 1'b1, t0); drain();
    do_issue(3'd6, 32'h80000000, 32'hffffffff, 6'd5, 4'd2, 1'b1, 32'h0, 1'b1, t0); drain();
    do_issue(3'd6, 32'd7, 32'd0, 6'd6, 4'd4, 1'b1, 32'd7, 1'b1, t0); drain();
    do_issue(3'd5, 32'd7, 32'd0, 6'd6, 4'd5, 1'b0, 32'hffffffff, 1'b1, t0); drain();
    do_issue(3'd1, 32'hffffffff, 32'h2, 6'd7, 4'd6, 1'b1, 32'hffffffff, 1'b1, t0); drain();
    do_issue(3'd3, 32'hffffffff, 32'h2, 6'd8, 4'd7, 1'b1, 32'h1, 1'b1, t0); drain();
    do_issue(3'd0, 32'hffffffff, 32'h2, 6'd9, 4'd8, 1'b1, 32'hfffffffe, 1'b1, t0); drain();
    do_issue(3'd2, 32'hffffffff, 32'h2, 6'd10, 4'd9, 1'b1, 32'hffffffff, 1'b1, t0); drain();
    do_issue(3'd6, 32'hffffff9c, 32'd7, 6'd11, 4'd10, 1'b1, 32'hfffffffe, 1'b1, t0); drain();
    do_issue(3'd4, 32'hffffff9c, 32'd7, 6'd11, 4'd11, 1'b1, 32'hfffffff2, 1'b1, t0); drain();

    // Recover at T+10 with tag 3 not live: squashed
    do_issue(3'd5, 32'd100, 32'd7, 6'd12, 4'd3, 1'b1, 32'd14, 1'b0, t0);
    while (cyc < t0 + 10) @(negedge clk);
    recover_i = 1'b1; live_tag_i = 16'hfff7;
    @(negedge clk);
    recover_i = 1'b0; live_tag_i = '1;
    #1;
    check_eq("recover_drop_busy",  64'(busy_o), 64'h0);
    check_eq("recover_drop_ready", 64'(issue_ready_o), 64'h1);
    repeat (30) @(negedge clk);

    // Recover at T+10 with tag 3 live: unaffected
    do_issue(3'd5, 32'd100, 32'd7, 6'd12, 4'd3, 1'b1, 32'd14, 1'b1, t0);
    while (cyc < t0 + 10) @(negedge clk);
    recover_i = 1'b1; live_tag_i = 16'h0008;
    @(negedge clk);
    recover_i = 1'b0; live_tag_i = '1;
    drain();

    // Flush at T+20, reissue at T+21
    do_issue(3'd5, 32'd500, 32'd3, 6'd13, 4'd12, 1'b1, 32'd166, 1'b0, t0);
    while (cyc < t0 + 20) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    do_issue(3'd7, 32'd500, 32'd3, 6'd14, 4'd13, 1'b1, 32'd2, 1'b1, t1);
    check_eq("flush_refire_cycle", 64'(t1), 64'(t0 + 21));
    drain();

    // Valid held while busy: granted once on return to IDLE
    do_issue(3'd0, 32'd6, 32'd7, 6'd15, 4'd14, 1'b1, 32'd42, 1'b1, t0);
    do_issue(3'd5, 32'd1000, 32'd10, 6'd16, 4'd15, 1'b1, 32'd100, 1'b1, t1);
    check_eq("held_grant_cycle", 64'(t1), 64'(t0 + exp_lat(3'd0, 32'd6, 32'd7) + 1));
    drain();

    // Reset mid-operation: no writeback
    do_issue(3'd5, 32'd100, 32'd7, 6'd17, 4'd1, 1'b1, 32'd14, 1'b0, t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midop_rst_busy", 64'(busy_o), 64'h0);
    check_eq("midop_rst_wb",   64'(wb_mdu_o), 64'h0);
    repeat (40) @(negedge clk);

    // Random operations against the reference model
    for (int k = 0; k < 12; k++) begin
      f3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k % 4 == 3) ? 32'h0 : $urandom;
      if (k % 5 == 1) rb = 32'($urandom_range(1, 9));
      do_issue(f3, ra, rb, 6'($urandom_range(0, 63)), 4'(k), 1'(k % 2),
               ref_mdu(f3, ra, rb), 1'b1, t0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
